ecc_core_ctrl: RTL and testbench
================================

Name: ecc_core_ctrl

Overview:
Multi-cycle sequencer for the ECC core datapath. Fetches 20-bit instructions from a synchronous instruction memory and decodes them. Drives register-file read and write selects, presents the instruction and PC to the ALU, and evaluates branch conditions from the NZP flags. It owns the PC, NZP flags, carry flag, halt state and a retired-instruction counter.

Parameters:
WORD_SIZE  64  datapath width
DADDR  4  register address MSB (16 registers)
INSN  19  instruction MSB (20-bit instruction)
IADDR  10  PC / imem address MSB (11-bit PC)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_start  in  1  leave IDLE and begin fetching at the current PC
i_imem_data  in  INSN+1  instruction word, valid the cycle after o_imem_en
o_imem_en  out  1  instruction read strobe
o_imem_addr  out  IADDR+1  instruction address (equals o_pc)
o_pc  out  IADDR+1  PC of the current instruction, to ALU
o_insn  out  INSN+1  latched instruction, to ALU
o_r1sel  out  DADDR+1  register read select 1 = insn[10:7]
o_r2sel  out  DADDR+1  register read select 2 = insn[6:3]
i_alu_result  in  WORD_SIZE  ALU result
i_carry_out  in  1  ALU carry-out
o_carry  out  1  carry flag, to ALU carry input
o_we  out  1  register write enable
o_wsel  out  DADDR+1  register write select = insn[14:11]
o_wdata  out  WORD_SIZE  write data
o_nzp  out  3  condition flags {N,Z,P}
o_busy  out  1  state is not IDLE and not HALT
o_halted  out  1  HALT state
o_retired  out  32  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, pc 0, insn 0, nzp 3'b010, carry 0, o_we 0, o_wdata 0, o_imem_en 0, o_retired 0.
- Reset asserted mid-instruction aborts the instruction immediately. No write or flag update occurs.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: if i_start, go to FETCH. Otherwise stay.
- FETCH: o_imem_en=1, o_imem_addr=pc. Next state DECODE.
- DECODE: latch insn <= i_imem_data. o_r1sel/o_r2sel are driven from the latched insn from the next cycle. Next state EXEC.
- EXEC: register data and ALU output are valid this cycle. Decode opcode = insn[19:15]:
  - 00000 NOP: pc <= pc+1; retire; go to FETCH.
  - 00001 BRz, 00010 BRzp, 00011 BRnp, 00100 BRnz: the condition uses the flags as they stand at EXEC.
    - Taken: pc <= i_alu_result[IADDR:0]. Not taken: pc <= pc+1.
    - Retire; go to FETCH. Flags are unchanged.
  - 11111 HALT: retire; go to HALT. pc is unchanged.
  - All other opcodes (ALU op): latch wdata <= i_alu_result and carry_next <= i_carry_out; go to WB.
- WB:
  - o_we=1 for exactly this cycle, o_wsel=insn[14:11], o_wdata=latched result.
  - nzp <= N if result[WORD_SIZE-1], else Z if result==0, else P. Exactly one bit is set.
  - carry <= carry_next; pc <= pc+1; retire; go to FETCH.
- HALT: o_halted=1; i_start is ignored. Only rst exits HALT.
- Latency per instruction: NOP and branches take 3 cycles (FETCH, DECODE, EXEC). ALU ops take 4 cycles. HALT takes 3 cycles to reach the HALT state.
- PC arithmetic is modulo 2^(IADDR+1): pc+1 from 0x7FF wraps to 0x000.
- o_retired increments by 1 on each retire and wraps from 2^32-1 to 0.
- o_we is never asserted outside WB.

Test Plan:
- Reset then i_start; imem[0]=NOP, imem[1]=HALT → o_imem_addr 0 then 1. o_halted rises 6 cycles after start. o_retired=2, pc=1.
- ALU op rd=5 whose ALU result is 0, i_carry_out=1 → single-cycle o_we with o_wsel=5, o_wdata=0. Then nzp=010, o_carry=1, pc+1.
- ALU op with result 0x8000_0000_0000_0000, then BRnz with i_alu_result=0x040 → branch taken, next fetch address 0x040. A following BRzp with nzp=100 is not taken: pc+1.
- PC=0x7FF executing NOP → next fetch address 0x000.
- rst asserted during WB → o_we=0 immediately. State IDLE, pc=0, nzp=010, o_retired=0. No further fetch until i_start.
- In HALT, pulse i_start → state remains HALT, o_busy=0, no o_imem_en.

Source files
------------

// File: rtl/ecc_core_ctrl.sv
// ecc_core_ctrl
// Multi-cycle sequencer for the ECC core datapath. Fetches 20-bit
// instructions from a synchronous instruction memory, decodes them,
// drives register-file selects, presents insn/PC to the ALU, evaluates
// NZP branch conditions, and writes ALU results back to the register file.
// It owns the PC, NZP flags, carry flag, halt state and retire counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           leave IDLE and begin fetching at the current PC
//   i_imem_data       instruction word, valid the cycle after o_imem_en
//   o_imem_en/addr    instruction read strobe / address (addr == o_pc)
//   o_pc, o_insn      current PC and latched instruction, to ALU
//   o_r1sel, o_r2sel  register read selects (insn[10:7], insn[6:3])
//   i_alu_result      ALU result (also the branch target in EXEC)
//   i_carry_out       ALU carry-out
//   o_carry           carry flag, to ALU carry input
//   o_we/wsel/wdata   register write port, active for one WB cycle
//   o_nzp             condition flags {N,Z,P}
//   o_busy, o_halted  sequencing status
//   o_retired         retired-instruction count (wraps)
//
// Handshake: there is no valid/ready back-pressure. o_imem_en is a
// one-cycle read strobe in FETCH; memory data is taken unconditionally in
// DECODE. o_we is a one-cycle write strobe in WB; the register file must
// accept it in that cycle.
module ecc_core_ctrl #(
  parameter int WORD_SIZE = 64,
  parameter int DADDR     = 4,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [INSN:0]        i_imem_data,
  output logic                 o_imem_en,
  output logic [IADDR:0]       o_imem_addr,
  output logic [IADDR:0]       o_pc,
  output logic [INSN:0]        o_insn,
  output logic [DADDR:0]       o_r1sel,
  output logic [DADDR:0]       o_r2sel,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  input  logic                 i_carry_out,
  output logic                 o_carry,
  output logic                 o_we,
  output logic [DADDR:0]       o_wsel,
  output logic [WORD_SIZE-1:0] o_wdata,
  output logic [2:0]           o_nzp,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic [31:0]          o_retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_BRZ  = 5'b00001;
  localparam logic [4:0] OP_BRZP = 5'b00010;
  localparam logic [4:0] OP_BRNP = 5'b00011;
  localparam logic [4:0] OP_BRNZ = 5'b00100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t         state;
  logic [IADDR:0] pc;
  logic [INSN:0]  insn;
  logic [2:0]     nzp;
  logic           carry;
  logic           carry_next;
  logic [31:0]    retired;
  logic [4:0]     opcode;
  logic           is_branch;
  logic           br_taken;

  assign opcode = insn[INSN:INSN-4];

  // Branch condition from the flags as they stand in EXEC; nzp = {N,Z,P}.
  always_comb begin
    is_branch = 1'b1;
    br_taken  = 1'b0;
    case (opcode)
      OP_BRZ:  br_taken = nzp[1];
      OP_BRZP: br_taken = nzp[1] | nzp[0];
      OP_BRNP: br_taken = nzp[2] | nzp[0];
      OP_BRNZ: br_taken = nzp[2] | nzp[1];
      default: is_branch = 1'b0;
    endcase
  end

  // o_imem_en and o_we are registered: they are set on the edge that
  // enters FETCH / WB and cleared on every other edge, so each is high
  // for exactly the one cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      insn       <= '0;
      nzp        <= 3'b010;
      carry      <= 1'b0;
      carry_next <= 1'b0;
      o_we       <= 1'b0;
      o_wdata    <= '0;
      o_imem_en  <= 1'b0;
      retired    <= '0;
    end else begin
      o_imem_en <= 1'b0;
      o_we      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_FETCH;
            o_imem_en <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          insn  <= i_imem_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == OP_NOP) begin
            pc        <= pc + 1'b1;
            retired   <= retired + 32'd1;
            state     <= S_FETCH;
            o_imem_en <= 1'b1;
          end else if (is_branch) begin
            pc        <= br_taken ? i_alu_result[IADDR:0] : pc + 1'b1;
            retired   <= retired + 32'd1;
            state     <= S_FETCH;
            o_imem_en <= 1'b1;
          end else if (opcode == OP_HALT) begin
            retired <= retired + 32'd1;
            state   <= S_HALT;
          end else begin
            o_wdata    <= i_alu_result;
            carry_next <= i_carry_out;
            o_we       <= 1'b1;
            state      <= S_WB;
          end
        end
        S_WB: begin
          if (o_wdata[WORD_SIZE-1])  nzp <= 3'b100;
          else if (o_wdata == '0)    nzp <= 3'b010;
          else                       nzp <= 3'b001;
          carry     <= carry_next;
          pc        <= pc + 1'b1;
          retired   <= retired + 32'd1;
          state     <= S_FETCH;
          o_imem_en <= 1'b1;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_addr = pc;
  assign o_pc        = pc;
  assign o_insn      = insn;
  assign o_r1sel     = insn[10:7];
  assign o_r2sel     = insn[6:3];
  assign o_wsel      = insn[14:11];
  assign o_carry     = carry;
  assign o_nzp       = nzp;
  assign o_retired   = retired;
  assign o_busy      = (state != S_IDLE) && (state != S_HALT);
  assign o_halted    = (state == S_HALT);

endmodule

// File: tb/tb_ecc_core_ctrl.sv
// Testbench for ecc_core_ctrl: instruction memory and ALU models, a
// fetch-address and write-port scoreboard, a vector table of single
// instructions after a flag-setting ALU op, and hand sequences for
// start/halt latency, PC wrap, reset during WB and start-in-HALT.
module tb_ecc_core_ctrl;

  localparam int WS = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [19:0]   i_imem_data = '0;
  logic          o_imem_en;
  logic [10:0]   o_imem_addr;
  logic [10:0]   o_pc;
  logic [19:0]   o_insn;
  logic [4:0]    o_r1sel;
  logic [4:0]    o_r2sel;
  logic [WS-1:0] i_alu_result;
  logic          i_carry_out;
  logic          o_carry;
  logic          o_we;
  logic [4:0]    o_wsel;
  logic [WS-1:0] o_wdata;
  logic [2:0]    o_nzp;
  logic          o_busy;
  logic          o_halted;
  logic [31:0]   o_retired;

  ecc_core_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_imem_data(i_imem_data),
    .o_imem_en(o_imem_en), .o_imem_addr(o_imem_addr), .o_pc(o_pc),
    .o_insn(o_insn), .o_r1sel(o_r1sel), .o_r2sel(o_r2sel),
    .i_alu_result(i_alu_result), .i_carry_out(i_carry_out), .o_carry(o_carry),
    .o_we(o_we), .o_wsel(o_wsel), .o_wdata(o_wdata), .o_nzp(o_nzp),
    .o_busy(o_busy), .o_halted(o_halted), .o_retired(o_retired)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory / ALU models ----------------
  localparam logic [19:0] HALT_I = 20'hFFFFF;
  logic [19:0]   mem     [2048];
  logic [WS-1:0] alu_tab [2048];
  logic          cy_tab  [2048];

  always @(posedge clk) if (o_imem_en) i_imem_data <= mem[o_imem_addr];
  assign i_alu_result = alu_tab[o_pc];
  assign i_carry_out  = cy_tab[o_pc];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_f_q[$];
  logic [68:0] exp_w_q[$];  // {wsel, wdata}
  int fetch_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (!rst && o_imem_en) begin
      fetch_seen++;
      if (exp_f_q.size() == 0) check("unexpected_fetch", {53'd0, o_imem_addr}, 64'hFFFF);
      else check("fetch_addr", {53'd0, o_imem_addr}, {53'd0, exp_f_q.pop_front()});
    end
    if (!rst && o_we) begin
      if (exp_w_q.size() == 0) begin
        check("unexpected_write", {59'd0, o_wsel}, 64'hFFFF);
      end else begin
        logic [68:0] e;
        e = exp_w_q.pop_front();
        check("wsel", {59'd0, o_wsel}, {59'd0, e[68:64]});
        check("wdata", o_wdata, e[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      mem[i] = HALT_I; alu_tab[i] = '0; cy_tab[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    int cyc = 0;
    while (!o_halted && cyc < max) begin
      @(posedge clk); #1; cyc++;
    end
    check("halt_reached", {63'd0, o_halted}, 64'd1);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_fetch_q_empty"}, exp_f_q.size(), 0);
    check({tag, "_write_q_empty"}, exp_w_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [63:0] setup_res;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [63:0] res;
    logic        cy;
    logic        is_alu;
    logic [10:0] exp_pc;
    logic [2:0]  exp_nzp;
    logic        exp_cy;
  } vec_t;

  localparam logic [63:0] NEG = 64'h8000_0000_0000_0000;
  vec_t vecs[14];

  initial begin
    int cyc;
    int en_cnt;

    vecs[0]  = '{"nop",       64'd5, 5'b00000, 4'd0,  64'd0,     1'b0, 1'b0, 11'd2,     3'b001, 1'b0};
    vecs[1]  = '{"brz_t",     64'd0, 5'b00001, 4'd0,  64'h40,    1'b0, 1'b0, 11'h040,   3'b010, 1'b0};
    vecs[2]  = '{"brz_nt",    64'd5, 5'b00001, 4'd0,  64'h40,    1'b0, 1'b0, 11'd2,     3'b001, 1'b0};
    vecs[3]  = '{"brzp_t",    64'd0, 5'b00010, 4'd0,  64'h123,   1'b0, 1'b0, 11'h123,   3'b010, 1'b0};
    vecs[4]  = '{"brzp_nt",   NEG,   5'b00010, 4'd0,  64'h123,   1'b0, 1'b0, 11'd2,     3'b100, 1'b0};
    vecs[5]  = '{"brnp_t",    NEG,   5'b00011, 4'd0,  64'h200,   1'b0, 1'b0, 11'h200,   3'b100, 1'b0};
    vecs[6]  = '{"brnp_nt",   64'd0, 5'b00011, 4'd0,  64'h200,   1'b0, 1'b0, 11'd2,     3'b010, 1'b0};
    vecs[7]  = '{"brnz_t",    NEG,   5'b00100, 4'd0,  64'h040,   1'b0, 1'b0, 11'h040,   3'b100, 1'b0};
    vecs[8]  = '{"brnz_nt",   64'd7, 5'b00100, 4'd0,  64'h040,   1'b0, 1'b0, 11'd2,     3'b001, 1'b0};
    vecs[9]  = '{"alu_zero",  64'd3, 5'b00110, 4'd5,  64'd0,     1'b1, 1'b1, 11'd2,     3'b010, 1'b1};
    vecs[10] = '{"alu_neg",   64'd0, 5'b00111, 4'd9,  {64{1'b1}},1'b0, 1'b1, 11'd2,     3'b100, 1'b0};
    vecs[11] = '{"alu_pos",   64'd0, 5'b11110, 4'd15, 64'd1,     1'b1, 1'b1, 11'd2,     3'b001, 1'b1};
    vecs[12] = '{"br_trunc",  64'd0, 5'b00001, 4'd0,  64'hFFFF_0000_0000_0555, 1'b0, 1'b0, 11'h555, 3'b010, 1'b0};
    vecs[13] = '{"brnp_t_p",  64'd5, 5'b00011, 4'd0,  64'h300,   1'b0, 1'b0, 11'h300,   3'b001, 1'b0};

    clear_mem();
    do_reset();

    // reset values
    check("rst_pc",      {53'd0, o_pc}, 64'd0);
    check("rst_insn",    {44'd0, o_insn}, 64'd0);
    check("rst_nzp",     {61'd0, o_nzp}, 64'd2);
    check("rst_carry",   {63'd0, o_carry}, 64'd0);
    check("rst_we",      {63'd0, o_we}, 64'd0);
    check("rst_wdata",   o_wdata, 64'd0);
    check("rst_imem_en", {63'd0, o_imem_en}, 64'd0);
    check("rst_retired", {32'd0, o_retired}, 64'd0);
    check("rst_busy",    {63'd0, o_busy}, 64'd0);
    check("rst_halted",  {63'd0, o_halted}, 64'd0);

    // ---- A: NOP then HALT, latency and selects ----
    mem[0] = {5'b00000, 4'd0, 4'd3, 4'hC, 3'd0};
    exp_f_q.push_back(11'd0);
    exp_f_q.push_back(11'd1);
    pulse_start();
    cyc = 0;
    while (!o_halted && cyc < 50) begin
      if (cyc == 2) begin
        check("a_r1sel", {59'd0, o_r1sel}, 64'd3);
        check("a_r2sel", {59'd0, o_r2sel}, 64'hC);
        check("a_busy",  {63'd0, o_busy}, 64'd1);
      end
      @(posedge clk); #1; cyc++;
    end
    check("a_halt_latency", cyc, 6);
    check("a_retired", {32'd0, o_retired}, 64'd2);
    check("a_pc", {53'd0, o_pc}, 64'd1);
    check_queues_empty("a");

    // ---- D: i_start ignored in HALT ----
    en_cnt = fetch_seen;
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("d_halted", {63'd0, o_halted}, 64'd1);
    check("d_busy",   {63'd0, o_busy}, 64'd0);
    check("d_no_fetch", fetch_seen - en_cnt, 0);

    // ---- vector table ----
    for (int v = 0; v < 14; v++) begin
      clear_mem();
      mem[0] = {5'b00101, 4'd1, 11'd0};
      alu_tab[0] = vecs[v].setup_res;
      mem[1] = {vecs[v].op, vecs[v].rd, 11'd0};
      alu_tab[1] = vecs[v].res;
      cy_tab[1]  = vecs[v].cy;
      do_reset();
      exp_f_q.push_back(11'd0);
      exp_f_q.push_back(11'd1);
      exp_f_q.push_back(vecs[v].exp_pc);
      exp_w_q.push_back({5'd1, vecs[v].setup_res});
      if (vecs[v].is_alu) exp_w_q.push_back({1'b0, vecs[v].rd, vecs[v].res});
      pulse_start();
      wait_halt(60);
      check({vecs[v].name, "_pc"},    {53'd0, o_pc}, {53'd0, vecs[v].exp_pc});
      check({vecs[v].name, "_nzp"},   {61'd0, o_nzp}, {61'd0, vecs[v].exp_nzp});
      check({vecs[v].name, "_carry"}, {63'd0, o_carry}, {63'd0, vecs[v].exp_cy});
      check({vecs[v].name, "_retired"}, {32'd0, o_retired}, 64'd3);
      check_queues_empty(vecs[v].name);
      exp_f_q.delete();
      exp_w_q.delete();
    end

    // ---- B: PC wrap 0x7FF -> 0x000 ----
    clear_mem();
    mem[0] = {5'b00001, 15'd0};   // BRz, taken from reset flags
    alu_tab[0] = 64'h7FF;
    mem[11'h7FF] = 20'd0;          // NOP
    do_reset();
    exp_f_q.push_back(11'd0);
    exp_f_q.push_back(11'h7FF);
    exp_f_q.push_back(11'd0);
    pulse_start();
    cyc = 0;
    while (!(o_imem_en && o_imem_addr == 11'h7FF) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check("b_reached_7ff", {53'd0, o_imem_addr}, 64'h7FF);
    mem[0] = HALT_I;
    wait_halt(40);
    check("b_pc_wrap", {53'd0, o_pc}, 64'd0);
    check("b_retired", {32'd0, o_retired}, 64'd3);
    check_queues_empty("b");
    exp_f_q.delete();

    // ---- C: reset asserted during WB ----
    clear_mem();
    mem[0] = {5'b00101, 4'd3, 11'd0};
    alu_tab[0] = 64'h55;
    cy_tab[0]  = 1'b1;
    do_reset();
    exp_f_q.push_back(11'd0);
    pulse_start();
    cyc = 0;
    while (!o_we && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("c_we_reached", {63'd0, o_we}, 64'd1);
    rst = 1'b1;
    #1;
    check("c_we_cleared", {63'd0, o_we}, 64'd0);
    check("c_busy",    {63'd0, o_busy}, 64'd0);
    check("c_halted",  {63'd0, o_halted}, 64'd0);
    check("c_pc",      {53'd0, o_pc}, 64'd0);
    check("c_nzp",     {61'd0, o_nzp}, 64'd2);
    check("c_carry",   {63'd0, o_carry}, 64'd0);
    check("c_retired", {32'd0, o_retired}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    en_cnt = fetch_seen;
    repeat (10) @(posedge clk);
    #1;
    check("c_no_fetch", fetch_seen - en_cnt, 0);
    check("c_idle_busy", {63'd0, o_busy}, 64'd0);
    check("c_nzp_after", {61'd0, o_nzp}, 64'd2);
    check_queues_empty("c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
